// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage plus MEM/WB pipeline register.
// Byte-lane little-endian data memory with sub-word loads/stores, alignment
// checking, a combinational debug read port and a stall input that freezes
// both the memory and the pipeline register.
module mem_stage #(
  parameter int NB_REG      = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_halt,
  input  logic                   i_mem_read_CU,
  input  logic                   i_mem_write_CU,
  input  logic                   i_mem_to_reg_CU,
  input  logic                   i_reg_write_CU,
  input  logic [1:0]             i_width_CU,
  input  logic                   i_unsigned_CU,
  input  logic [NB_REG-1:0]      i_alu_result,
  input  logic [NB_REG-1:0]      i_write_data,
  input  logic [NB_ADDR-1:0]     i_write_reg,
  input  logic [NB_MEM_ADDR-1:0] i_debug_addr,
  output logic [NB_REG-1:0]      o_debug_data,
  output logic                   o_reg_write,
  output logic                   o_mem_to_reg,
  output logic [NB_REG-1:0]      o_read_data,
  output logic [NB_REG-1:0]      o_alu_result,
  output logic [NB_ADDR-1:0]     o_write_reg,
  output logic                   o_misaligned
);

  localparam int N_LANES = NB_REG / 8;
  localparam int DEPTH   = 2 ** NB_MEM_ADDR;

  // Access width encoding; the unused code 2'b10 behaves as a word access.
  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_RSVD = 2'b10,
    WIDTH_WORD = 2'b11
  } width_t;

  logic [NB_REG-1:0]      mem [DEPTH];
  logic [NB_MEM_ADDR-1:0] word_idx;
  logic [1:0]             byte_off;
  width_t                 width;
  logic                   misaligned;
  logic                   store_en;
  logic [N_LANES-1:0]     lane_en;
  logic [NB_REG-1:0]      store_data;
  logic [NB_REG-1:0]      mem_word;
  logic [7:0]             load_byte;
  logic [15:0]            load_half;
  logic [NB_REG-1:0]      load_data;

  // Upper address bits are dropped, so the memory aliases modulo its depth.
  assign word_idx = i_alu_result[NB_MEM_ADDR+1:2];
  assign byte_off = i_alu_result[1:0];
  assign width    = width_t'(i_width_CU);
  assign store_en = i_mem_write_CU && !misaligned && !i_halt;

  // Alignment check: bytes never fault, halves need an even address, words a multiple of 4.
  always_comb begin
    misaligned = 1'b0;
    case (width)
      WIDTH_BYTE: misaligned = 1'b0;
      WIDTH_HALF: misaligned = byte_off[0];
      default:    misaligned = |byte_off;
    endcase
  end

  // Lane enables and lane-replicated store data, so each lane just takes its own slice.
  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    lane_en    = '0;
    store_data = i_write_data;
    case (width)
      WIDTH_BYTE: begin
        lane_en[byte_off] = 1'b1;
        store_data        = {N_LANES{i_write_data[7:0]}};
      end
      WIDTH_HALF: begin
        lane_en[{byte_off[1], 1'b0}] = 1'b1;
        lane_en[{byte_off[1], 1'b1}] = 1'b1;
        store_data                   = {(N_LANES/2){i_write_data[15:0]}};
      end
      default: lane_en = '1;
    endcase
  end

  // Byte-lane store; the read below sees the pre-write word in the same cycle.
  // NOTE: the memory array has no reset -- its contents must survive i_rst_n and it maps to RAM.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  assign mem_word  = mem[word_idx];
  assign load_byte = mem_word[{byte_off, 3'b000} +: 8];
  assign load_half = mem_word[{byte_off[1], 4'b0000} +: 16];

  // Lane select and sign/zero extension; faulting or non-load accesses return zero.
  always_comb begin
    load_data = '0;
    if (i_mem_read_CU && !misaligned) begin
      case (width)
        WIDTH_BYTE: load_data = {{(NB_REG-8){!i_unsigned_CU && load_byte[7]}}, load_byte};
        WIDTH_HALF: load_data = {{(NB_REG-16){!i_unsigned_CU && load_half[15]}}, load_half};
        default:    load_data = mem_word;
      endcase
    end
  end

  assign o_debug_data = mem[i_debug_addr];

  // MEM/WB register: cleared asynchronously, frozen while halted.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_misaligned <= 1'b0;
    end else if (!i_halt) begin
      o_misaligned <= misaligned && (i_mem_read_CU || i_mem_write_CU);
      o_reg_write  <= i_reg_write_CU && !(misaligned && (i_mem_read_CU || i_mem_write_CU));
      o_mem_to_reg <= i_mem_to_reg_CU;
      o_read_data  <= load_data;
      o_alu_result <= i_alu_result;
      o_write_reg  <= i_write_reg;
    end
  end

endmodule
